fc_bias_stream: RTL and testbench

- Sequential, parametrised successor to the combinational FC bias adder at the classifier output of the digit-classification CNN.
- Accepts FC accumulator results as a stream, one channel per beat, over a valid/ready handshake.
- Adds a per-channel bias held in an internal, runtime-loadable bias file.
- Saturates each sum to the output width and tracks the running argmax, producing the predicted class at the end of each frame.

---
 rtl/fc_pkg.sv | 26 ++
 rtl/fc_argmax_tracker.sv | 27 ++
 rtl/fc_bias_stream.sv | 104 ++++++++++
 tb/tb_fc_bias_stream.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared constants and signed saturation for the FC classifier output stage
package fc_pkg;

  localparam int N_CLASSES = 10;
  localparam int FC_ACC_W  = 64;
  localparam int FC_BIAS_W = 6;

  // Widest value sat_s can clamp; callers sign-extend into this width.
  localparam int SAT_MAX_W = 128;

  function automatic logic signed [SAT_MAX_W-1:0] sat_s(
    input logic signed [SAT_MAX_W-1:0] value,
    input int                          w_out
  );
    logic signed [SAT_MAX_W-1:0] hi;
    logic signed [SAT_MAX_W-1:0] lo;
    if (w_out >= SAT_MAX_W) return value;
    hi = '1;
    hi = hi >> (SAT_MAX_W - w_out + 1);
    lo = ~hi;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fc_argmax_tracker.sv
// rtl/fc_argmax_tracker.sv - running signed maximum and its index over a stream of scored beats
module fc_argmax_tracker #(
  parameter int W     = 64,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic             first,
  input  logic [W-1:0]     value,
  input  logic [IDX_W-1:0] idx,
  output logic [W-1:0]     max_val,
  output logic [IDX_W-1:0] max_idx
);

  // Strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_val <= '0;
      max_idx <= '0;
    end else if (valid && (first || ($signed(value) > $signed(max_val)))) begin
      max_val <= value;
      max_idx <= idx;
    end
  end

endmodule

// File: rtl/fc_bias_stream.sv
// rtl/fc_bias_stream.sv - streaming FC bias add with saturation and per-frame argmax
module fc_bias_stream
  import fc_pkg::*;
#(
  parameter int  W_IN   = FC_ACC_W,
  parameter int  W_BIAS = FC_BIAS_W,
  parameter int  W_OUT  = FC_ACC_W,
  parameter int  N_CH   = N_CLASSES,
  localparam int IDX_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bias_we,
  input  logic [IDX_W-1:0]  bias_addr,
  input  logic [W_BIAS-1:0] bias_wdata,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [W_IN-1:0]   in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W_OUT-1:0]  out_data,
  output logic [IDX_W-1:0]  out_ch,
  output logic              cls_valid,
  output logic [IDX_W-1:0]  cls_idx,
  output logic [W_OUT-1:0]  cls_score,
  output logic              err_len
);

  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_CH - 1);

  logic [W_BIAS-1:0] bias_q [N_CH];
  logic [IDX_W-1:0]  ch_cnt;
  logic [W_BIAS-1:0] bias_rd;
  logic [W_IN:0]     sum;
  logic [W_OUT-1:0]  sat_val;
  logic              accept;
  logic              first_beat;
  logic              last_beat;
  logic [W_OUT-1:0]  max_val;
  logic [IDX_W-1:0]  max_idx;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_beat = (ch_cnt == '0);
  assign last_beat  = (ch_cnt == LAST_CH);

  // One extra bit of headroom means the add itself can never wrap.
  assign bias_rd = bias_q[ch_cnt];
  assign sum     = {in_data[W_IN-1], in_data}
                 + {{(W_IN + 1 - W_BIAS){bias_rd[W_BIAS-1]}}, bias_rd};
  assign sat_val = W_OUT'(sat_s(SAT_MAX_W'($signed(sum)), W_OUT));

  fc_argmax_tracker #(
    .W     (W_OUT),
    .IDX_W (IDX_W)
  ) u_argmax (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (accept),
    .first   (first_beat),
    .value   (sat_val),
    .idx     (ch_cnt),
    .max_val (max_val),
    .max_idx (max_idx)
  );

  // Tracker updates on the same edge as the output register, so it already includes the final beat.
  assign cls_idx   = cls_valid ? max_idx : '0;
  assign cls_score = cls_valid ? max_val : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      cls_valid <= 1'b0;
      err_len   <= 1'b0;
      ch_cnt    <= '0;
    end else begin
      err_len <= accept && (in_last != last_beat);
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sat_val;
        out_ch    <= ch_cnt;
        cls_valid <= last_beat;
        ch_cnt    <= (last_beat || in_last) ? '0 : ch_cnt + 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        cls_valid <= 1'b0;
      end
    end
  end

  // A same-cycle read sees the old entry because the write lands on the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) bias_q[i] <= '0;
    end else if (bias_we && (int'(bias_addr) < N_CH)) begin
      bias_q[bias_addr] <= bias_wdata;
    end
  end

endmodule

// File: tb/tb_fc_bias_stream.sv
// tb/tb_fc_bias_stream.sv - randomized bench for fc_bias_stream against a frame-level reference model
module tb_fc_bias_stream;

  localparam int N = 10;

  typedef struct packed {
    logic [63:0] d64;
    logic [7:0]  d8;
    logic [3:0]  ch;
    logic        cv;
    logic [3:0]  ci64;
    logic [3:0]  ci8;
    logic [63:0] s64;
    logic [7:0]  s8;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bias_we = 1'b0;
  logic [3:0]  bias_addr = '0;
  logic [5:0]  bias_wdata = '0;
  logic        in_valid = 1'b0;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, cls_valid, err_len;
  logic [63:0] out_data, cls_score;
  logic [3:0]  out_ch, cls_idx;
  logic        rdy8, ov8, cv8, er8;
  logic [7:0]  od8, cs8;
  logic [3:0]  och8, ci8;

  int n_chk = 0, n_fail = 0;
  int err_seen = 0, exp_err = 0, cls_seen = 0, exp_cls = 0;
  int rdy_mode = 0;
  logic [3:0]  last_ci, last_ci8;
  logic [63:0] last_s64;
  logic [7:0]  last_s8;
  logic [63:0] obs_d [16];

  logic [5:0]               mb [N];
  int                       mcnt = 0;
  logic signed [127:0]      fv64[$];
  logic signed [127:0]      fv8[$];
  exp_t                     exp_q[$];
  exp_t                     mon_e;

  fc_bias_stream u_dut (
    .clk(clk), .rst_n(rst_n), .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .cls_valid(cls_valid), .cls_idx(cls_idx), .cls_score(cls_score), .err_len(err_len)
  );

  fc_bias_stream #(.W_OUT(8)) u_sat (
    .clk(clk), .rst_n(rst_n), .bias_we(bias_we), .bias_addr(bias_addr), .bias_wdata(bias_wdata),
    .in_valid(in_valid), .in_ready(rdy8), .in_data(in_data), .in_last(in_last),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_ch(och8),
    .cls_valid(cv8), .cls_idx(ci8), .cls_score(cs8), .err_len(er8)
  );

  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [127:0] clampw(input logic signed [127:0] v, input int w);
    logic signed [127:0] hi, lo;
    hi = (128'sd1 <<< (w - 1)) - 128'sd1;
    lo = -hi - 128'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: bias add in wide arithmetic, clamp, argmax by scanning the whole frame.
  task automatic model_accept(input logic [63:0] d, input logic last);
    exp_t e;
    logic signed [127:0] s, v64, v8, t;
    logic [5:0] b;
    int bi;
    b   = mb[mcnt];
    s   = {{64{d[63]}}, d} + {{122{b[5]}}, b};
    v64 = clampw(s, 64);
    v8  = clampw(s, 8);
    fv64.push_back(v64);
    fv8.push_back(v8);
    e = '0;
    e.d64 = v64[63:0];
    e.d8  = v8[7:0];
    e.ch  = mcnt[3:0];
    e.cv  = (mcnt == N - 1);
    if (e.cv) begin
      bi = 0;
      for (int i = 1; i < fv64.size(); i++) if (fv64[i] > fv64[bi]) bi = i;
      t = fv64[bi];
      e.ci64 = bi[3:0];
      e.s64  = t[63:0];
      bi = 0;
      for (int i = 1; i < fv8.size(); i++) if (fv8[i] > fv8[bi]) bi = i;
      t = fv8[bi];
      e.ci8 = bi[3:0];
      e.s8  = t[7:0];
      exp_cls++;
    end
    if (last != e.cv) exp_err++;
    if (e.cv || last) begin
      mcnt = 0;
      fv64.delete();
      fv8.delete();
    end else begin
      mcnt++;
    end
    exp_q.push_back(e);
  endtask

  task automatic push_beat(input logic [63:0] d, input logic last,
                           input logic we = 1'b0, input logic [3:0] wa = '0, input logic [5:0] wd = '0);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    bias_we = we; bias_addr = wa; bias_wdata = wd;
    for (int cyc = 0; cyc < 200 && !acc; cyc++) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) model_accept(d, last);
      if (bias_we && int'(bias_addr) < N) mb[bias_addr] = bias_wdata;
      @(posedge clk);
      #1;
      bias_we = 1'b0;
    end
    in_valid = 1'b0; in_last = 1'b0;
    n_chk++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: beat %h never accepted, in_ready=%b", d, in_ready);
    end
  endtask

  task automatic write_bias(input logic [3:0] a, input logic [5:0] v);
    bias_we = 1'b1; bias_addr = a; bias_wdata = v;
    @(posedge clk);
    #1;
    bias_we = 1'b0;
    if (int'(a) < N) mb[a] = v;
  endtask

  task automatic drain();
    for (int cyc = 0; cyc < 500 && exp_q.size() != 0; cyc++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_data();
    int t;
    if ($urandom_range(0, 2) == 0) return {$urandom, $urandom};
    t = int'($urandom_range(0, 400)) - 200;
    return 64'(t);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (err_len) err_seen++;
      n_chk++;
      if (rdy8 !== in_ready || in_ready !== (!out_valid || out_ready)) begin
        n_fail++;
        $display("FAIL in_ready: got %b/%b required %b", in_ready, rdy8, !out_valid || out_ready);
      end
      n_chk++;
      if (ov8 !== out_valid || er8 !== err_len || och8 !== out_ch) begin
        n_fail++;
        $display("FAIL lockstep: out_valid %b/%b err_len %b/%b", out_valid, ov8, err_len, er8);
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: out_data=%h out_ch=%0d", out_data, out_ch);
        end else begin
          mon_e = exp_q.pop_front();
          if ({out_data, od8, out_ch, cls_valid, cv8} !== {mon_e.d64, mon_e.d8, mon_e.ch, mon_e.cv, mon_e.cv}) begin
            n_fail++;
            $display("FAIL out_beat: got data=%h/%h ch=%0d cls=%b/%b required data=%h/%h ch=%0d cls=%b",
                     out_data, od8, out_ch, cls_valid, cv8, mon_e.d64, mon_e.d8, mon_e.ch, mon_e.cv);
          end
          if (mon_e.cv) begin
            n_chk++;
            if ({cls_idx, ci8, cls_score, cs8} !== {mon_e.ci64, mon_e.ci8, mon_e.s64, mon_e.s8}) begin
              n_fail++;
              $display("FAIL cls_result: got idx=%0d/%0d score=%h/%h required idx=%0d/%0d score=%h/%h",
                       cls_idx, ci8, cls_score, cs8, mon_e.ci64, mon_e.ci8, mon_e.s64, mon_e.s8);
            end
          end
        end
        if (cls_valid) begin
          cls_seen++;
          last_ci = cls_idx; last_ci8 = ci8; last_s64 = cls_score; last_s8 = cs8;
        end
        obs_d[out_ch] = out_data;
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++;
    if ({out_valid, cls_valid, err_len, out_data, out_ch, cls_idx, cls_score} !== '0 ||
        {ov8, cv8, er8, od8, och8, ci8, cs8} !== '0 || in_ready !== 1'b1 || rdy8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: out_valid=%b out_data=%h cls_valid=%b in_ready=%b required zeros and in_ready=1",
               out_valid, out_data, cls_valid, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_defaults();
    int c0;
    c0 = cls_seen;
    for (int i = 0; i < N; i++) write_bias(4'(i), 6'(i + 1));
    for (int i = 0; i < N; i++) push_beat(64'd100, i == N - 1);
    drain();
    n_chk++;
    if (cls_seen != c0 + 1 || last_ci !== 4'd9 || last_s64 !== 64'd110 || last_s8 !== 8'd110) begin
      n_fail++;
      $display("FAIL defaults_cls: got count=%0d idx=%0d score=%0d required count=%0d idx=9 score=110",
               cls_seen - c0, last_ci, last_s64, 1);
    end
    n_chk++;
    if (obs_d[0] !== 64'd101 || obs_d[9] !== 64'd110) begin
      n_fail++;
      $display("FAIL defaults_data: got ch0=%0d ch9=%0d required 101 110", obs_d[0], obs_d[9]);
    end
  endtask

  task automatic test_saturation();
    write_bias(4'd0, 6'h05);
    write_bias(4'd1, 6'h3D);
    write_bias(4'd2, 6'h1F);
    write_bias(4'd3, 6'h20);
    push_beat(64'd200, 1'b0);
    push_beat(-64'sd300, 1'b0);
    push_beat(64'h7FFF_FFFF_FFFF_FFFE, 1'b0);
    push_beat(64'h8000_0000_0000_0001, 1'b0);
    for (int i = 4; i < N; i++) push_beat(rand_data(), i == N - 1);
    drain();
    for (int i = 0; i < N; i++) write_bias(4'(i), 6'h00);
    for (int i = 0; i < N; i++) push_beat((i == 2 || i == 7) ? 64'd50 : 64'd0, i == N - 1);
    drain();
    n_chk++;
    if (last_ci !== 4'd2 || last_ci8 !== 4'd2 || last_s8 !== 8'd50) begin
      n_fail++;
      $display("FAIL tie_argmax: got idx=%0d/%0d score=%0d required idx=2 score=50", last_ci, last_ci8, last_s8);
    end
  endtask

  task automatic test_backpressure();
    int c0;
    c0 = cls_seen;
    rdy_mode = 1;
    for (int i = 0; i < N; i++) write_bias(4'(i), 6'($urandom));
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        push_beat(rand_data(), i == N - 1);
      end
    end
    drain();
    rdy_mode = 0;
    drain();
    n_chk++;
    if (exp_q.size() != 0 || cls_seen != c0 + 4) begin
      n_fail++;
      $display("FAIL backpressure_count: got pending=%0d frames=%0d required 0 and 4", exp_q.size(), cls_seen - c0);
    end
  endtask

  task automatic test_short_frame();
    int e0, c0;
    e0 = err_seen; c0 = cls_seen;
    for (int i = 0; i < 5; i++) push_beat(rand_data(), i == 4);
    for (int i = 0; i < N; i++) push_beat(rand_data(), i == N - 1);
    drain();
    n_chk++;
    if (err_seen != e0 + 1 || cls_seen != c0 + 1 || err_seen != exp_err) begin
      n_fail++;
      $display("FAIL short_frame: got err=%0d cls=%0d required err=1 cls=1", err_seen - e0, cls_seen - c0);
    end
  endtask

  task automatic test_long_frame();
    int e0, c0;
    e0 = err_seen; c0 = cls_seen;
    for (int i = 0; i < N; i++) push_beat(rand_data(), 1'b0);
    for (int i = 0; i < N; i++) push_beat(rand_data(), i == N - 1);
    drain();
    n_chk++;
    if (err_seen != e0 + 1 || cls_seen != c0 + 2 || err_seen != exp_err) begin
      n_fail++;
      $display("FAIL long_frame: got err=%0d cls=%0d required err=1 cls=2", err_seen - e0, cls_seen - c0);
    end
  endtask

  task automatic test_bias_collision();
    write_bias(4'd3, 6'd2);
    write_bias(4'd12, 6'd9);
    for (int i = 0; i < 3; i++) push_beat(rand_data(), 1'b0);
    push_beat(64'd100, 1'b0, 1'b1, 4'd3, 6'h39);
    for (int i = 4; i < N; i++) push_beat(rand_data(), i == N - 1);
    drain();
    n_chk++;
    if (obs_d[3] !== 64'd102) begin
      n_fail++;
      $display("FAIL collision_old: got ch3=%0d required 102", $signed(obs_d[3]));
    end
    for (int i = 0; i < N; i++) push_beat(i == 3 ? 64'd100 : rand_data(), i == N - 1);
    drain();
    n_chk++;
    if (obs_d[3] !== 64'd93) begin
      n_fail++;
      $display("FAIL collision_new: got ch3=%0d required 93", $signed(obs_d[3]));
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) push_beat(rand_data(), 1'b0);
    rdy_mode = 2;
    repeat (2) begin @(posedge clk); #1; end
    push_beat(rand_data(), 1'b0);
    @(posedge clk);
    #1;
    n_chk++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_hold: got out_valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({out_valid, cls_valid, err_len, out_data, out_ch, cls_idx, cls_score} !== '0 ||
        {ov8, cv8, er8, od8, och8} !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: got out_valid=%b out_data=%h in_ready=%b required zeros and in_ready=1",
               out_valid, out_data, in_ready);
    end
    exp_q.delete(); fv64.delete(); fv8.delete();
    mcnt = 0;
    for (int i = 0; i < N; i++) mb[i] = '0;
    rdy_mode = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) push_beat(64'(i * 7), i == N - 1);
    drain();
    n_chk++;
    if (obs_d[5] !== 64'd35 || last_ci !== 4'd9) begin
      n_fail++;
      $display("FAIL post_reset_bias: got ch5=%0d idx=%0d required 35 9", obs_d[5], last_ci);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mb[i] = '0;
    for (int i = 0; i < 16; i++) obs_d[i] = '0;
    test_reset();
    test_defaults();
    test_saturation();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_bias_collision();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
